// File: rtl/clk_strobe_pkg.sv
// Shared types and helpers for the clock-enable strobe generator.
// Config fields are sized to DIV_W_MAX; channels use the low DIV_W bits.
package clk_strobe_pkg;

  localparam int DIV_W_MAX = 16;
  localparam int DEF_DIV_RST = 27;
  localparam bit DEF_EN_RST = 1'b1;

  typedef struct packed {
    logic                 en;
    logic                 turbo;
    logic [DIV_W_MAX-1:0] div;
    logic [DIV_W_MAX-1:0] phase;
  } ch_cfg_t;

  function automatic logic [DIV_W_MAX-1:0] half_phase(
    input logic [DIV_W_MAX-1:0] phase,
    input logic [DIV_W_MAX-1:0] div
  );
    logic [DIV_W_MAX:0] per;
    logic [DIV_W_MAX:0] sum;
    per = {1'b0, div} + (DIV_W_MAX+1)'(1);
    sum = {1'b0, phase} + (per >> 1);
    return DIV_W_MAX'(sum % per);
  endfunction

  function automatic ch_cfg_t rst_cfg(
    input int div,
    input bit en
  );
    ch_cfg_t c;
    c.en    = en;
    c.turbo = 1'b0;
    c.div   = DIV_W_MAX'(div);
    c.phase = '0;
    return c;
  endfunction

endpackage

// File: rtl/clk_strobe_ch.sv
// One strobe channel: counter, shadow/active config, compare, output flops.
// Shadow config is promoted to active only at wrap or on resync.
module clk_strobe_ch
  import clk_strobe_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = DEF_DIV_RST,
  parameter bit DEF_EN  = DEF_EN_RST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  input  logic               cfg_turbo,
  input  logic               cfg_en,
  input  logic               resync,
  input  logic               pause,
  output logic               stb,
  output logic               wrap,
  output logic [2*DIV_W+1:0] act_rdata
);

  localparam ch_cfg_t RST = rst_cfg(DEF_DIV, DEF_EN);

  ch_cfg_t              wr_cfg;
  ch_cfg_t              shd;
  ch_cfg_t              act;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W_MAX-1:0] cnt_x;
  logic [DIV_W_MAX-1:0] ph2;
  logic                 at_end;
  logic                 hit;

  always_comb begin
    wr_cfg.en    = cfg_en;
    wr_cfg.turbo = cfg_turbo;
    wr_cfg.div   = DIV_W_MAX'(cfg_div);
    wr_cfg.phase = DIV_W_MAX'(cfg_phase);
  end

  assign cnt_x  = DIV_W_MAX'(cnt);
  assign ph2    = half_phase(act.phase, act.div);
  assign at_end = (cnt_x == act.div);
  assign hit    = act.en &&
                  ((cnt_x == act.phase) ||
                   (act.turbo && (cnt_x == ph2)));

  assign act_rdata = {act.en, act.turbo,
                      act.div[DIV_W-1:0],
                      act.phase[DIV_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      shd  <= RST;
      act  <= RST;
      stb  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      if (cfg_we) shd <= wr_cfg;
      if (resync) begin
        cnt  <= '0;
        act  <= cfg_we ? wr_cfg : shd;
        stb  <= 1'b0;
        wrap <= 1'b0;
      end else if (pause) begin
        stb  <= 1'b0;
        wrap <= 1'b0;
      end else begin
        stb  <= hit;
        wrap <= at_end;
        if (at_end) begin
          cnt <= '0;
          act <= shd;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable strobe generator (CPU phases, pixel, PIT...).
// Channel select decode for config writes and active-config readback.
module clk_strobe_gen
  import clk_strobe_pkg::*;
#(
  parameter int NUM_CH  = 6,
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = DEF_DIV_RST,
  parameter bit DEF_EN  = DEF_EN_RST,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  input  logic               cfg_turbo,
  input  logic               cfg_en,
  input  logic               resync,
  input  logic               pause,
  output logic [NUM_CH-1:0]  stb,
  output logic [NUM_CH-1:0]  wrap,
  output logic [2*DIV_W+1:0] act_rdata
);

  logic [2*DIV_W+1:0] rd [NUM_CH];
  logic [NUM_CH-1:0]  we_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_strobe_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .DEF_EN  (DEF_EN)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (we_ch[i]),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_turbo (cfg_turbo),
      .cfg_en    (cfg_en),
      .resync    (resync),
      .pause     (pause),
      .stb       (stb[i]),
      .wrap      (wrap[i]),
      .act_rdata (rd[i])
    );
  end

  always_comb begin
    act_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) act_rdata = rd[i];
    end
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Bench for clk_strobe_gen: period-level model plus directed timing checks.
module tb_clk_strobe_gen;

  localparam int N = 6;
  localparam int W = 12;
  localparam int HN = 8192;

  typedef struct {
    int en;
    int tb;
    int dv;
    int ph;
  } mcfg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic [W-1:0] cfg_phase = '0;
  logic cfg_turbo = 1'b0;
  logic cfg_en = 1'b0;
  logic resync = 1'b0;
  logic pause = 1'b0;
  logic [N-1:0] stb;
  logic [N-1:0] wrap;
  logic [2*W+1:0] act_rdata;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  logic [N-1:0] h_stb [HN];
  logic [N-1:0] h_wrap [HN];

  int m_cnt [N];
  mcfg_t m_act [N];
  mcfg_t m_shd [N];
  logic [N-1:0] e_stb = '0;
  logic [N-1:0] e_wrap = '0;

  always #5 clk = ~clk;

  clk_strobe_gen dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_turbo (cfg_turbo),
    .cfg_en    (cfg_en),
    .resync    (resync),
    .pause     (pause),
    .stb       (stb),
    .wrap      (wrap),
    .act_rdata (act_rdata)
  );

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: each channel is a position modulo its period.
  always @(posedge clk) begin
    mcfg_t nw;
    mcfg_t df;
    bit wr;
    int per;
    cyc = cyc + 1;
    nw.en = int'(cfg_en);
    nw.tb = int'(cfg_turbo);
    nw.dv = int'(cfg_div);
    nw.ph = int'(cfg_phase);
    df.en = 1; df.tb = 0; df.dv = 27; df.ph = 0;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_cnt[i] = 0;
        m_act[i] = df;
        m_shd[i] = df;
        e_stb[i] = 1'b0;
        e_wrap[i] = 1'b0;
      end else begin
        wr = cfg_we && (int'(cfg_ch) == i);
        per = m_act[i].dv + 1;
        if (resync) begin
          m_cnt[i] = 0;
          m_act[i] = wr ? nw : m_shd[i];
          e_stb[i] = 1'b0;
          e_wrap[i] = 1'b0;
        end else if (pause) begin
          e_stb[i] = 1'b0;
          e_wrap[i] = 1'b0;
        end else begin
          e_stb[i] = (m_act[i].en != 0) &&
            (m_cnt[i] == m_act[i].ph ||
             (m_act[i].tb != 0 &&
              m_cnt[i] == (m_act[i].ph + per / 2) % per));
          e_wrap[i] = (m_cnt[i] == per - 1);
          m_cnt[i] = (m_cnt[i] + 1) % per;
          if (e_wrap[i]) m_act[i] = m_shd[i];
        end
        if (wr) m_shd[i] = nw;
      end
    end
  end

  always @(negedge clk) begin
    int idx;
    logic [2*W+1:0] er;
    h_stb[cyc % HN] = stb;
    h_wrap[cyc % HN] = wrap;
    if (chk_on) begin
      check("stb", 64'(stb), 64'(e_stb));
      check("wrap", 64'(wrap), 64'(e_wrap));
      idx = int'(cfg_ch);
      if (idx < N) begin
        er = {1'(m_act[idx].en), 1'(m_act[idx].tb),
              W'(m_act[idx].dv), W'(m_act[idx].ph)};
        check("act_rdata", 64'(act_rdata), 64'(er));
      end
    end
  end

  function automatic logic [63:0] win(input int ch, input int st,
                                      input int len, input bit w);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < len; k++)
      v[k] = w ? h_wrap[(st + k) % HN][ch] : h_stb[(st + k) % HN][ch];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_cfg(input int ch, input int dv, input int ph,
                        input bit tb, input bit en);
    cfg_we = 1'b1;
    cfg_ch = 3'(ch);
    cfg_div = W'(dv);
    cfg_phase = W'(ph);
    cfg_turbo = tb;
    cfg_en = en;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic do_resync(output int r);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    r = cyc;
  endtask

  function automatic logic [63:0] bits(input int a, input int b,
                                       input int c, input int d,
                                       input int e);
    logic [63:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  initial begin
    int r;
    tick(3);
    chk_on = 1'b1;
    check("rst_stb", 64'(stb), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_rd", 64'(act_rdata), 64'({1'b1, 1'b0, 12'd27, 12'd0}));
    reset = 1'b0;
    r = cyc;
    tick(60);
    check("t1_stb0", win(0, r + 1, 56, 0), bits(0, 28, -1, -1, -1));
    check("t1_wrap0", win(0, r + 1, 56, 1), bits(27, 55, -1, -1, -1));

    wr_cfg(0, 27, 0, 1, 1);
    wr_cfg(1, 27, 2, 1, 1);
    do_resync(r);
    tick(40);
    check("t2_f1", win(0, r + 1, 28, 0), bits(0, 14, -1, -1, -1));
    check("t2_f2", win(1, r + 1, 28, 0), bits(2, 16, -1, -1, -1));

    wr_cfg(2, 9, 0, 0, 1);
    do_resync(r);
    wr_cfg(2, 5, 0, 0, 1);
    tick(40);
    check("t3_div", win(2, r + 1, 30, 0), bits(0, 10, 16, 22, 28));

    wr_cfg(3, 0, 0, 0, 1);
    do_resync(r);
    tick(24);
    check("t4_div0", win(3, r + 1, 20, 0), 64'hFFFFF);
    wr_cfg(3, 3, 7, 0, 1);
    do_resync(r);
    tick(24);
    check("t4_oor_stb", win(3, r + 1, 20, 0), 64'd0);
    check("t4_oor_wrap", win(3, r + 1, 20, 1), bits(3, 7, 11, 15, 19));
    wr_cfg(3, 1, 0, 1, 1);
    do_resync(r);
    tick(24);
    check("t4_div1_turbo", win(3, r + 1, 20, 0), 64'hFFFFF);

    wr_cfg(0, 27, 0, 0, 1);
    do_resync(r);
    tick(10);
    pause = 1'b1;
    tick(50);
    pause = 1'b0;
    tick(45);
    check("t5_pre_stb", win(0, r + 1, 60, 0), 64'd1);
    check("t5_pre_wrap", win(0, r + 1, 60, 1), 64'd0);
    check("t5_post_stb", win(0, r + 61, 40, 0), 64'd1 << 18);
    check("t5_post_wrap", win(0, r + 61, 40, 1), 64'd1 << 17);

    wr_cfg(1, 7, 0, 0, 1);
    do_resync(r);
    tick(7);
    wr_cfg(1, 3, 1, 0, 1);
    tick(30);
    check("t6_ch1_stb", win(1, r + 1, 28, 0), bits(0, 8, 17, 21, 25));
    check("t6_ch1_wrap", win(1, r + 1, 28, 1), bits(7, 15, 19, 23, 27));

    cfg_we = 1'b1;
    cfg_ch = 3'd0;
    cfg_div = 12'd4;
    cfg_phase = 12'd2;
    cfg_turbo = 1'b0;
    cfg_en = 1'b1;
    do_resync(r);
    cfg_we = 1'b0;
    tick(20);
    check("t6_ch0_stb", win(0, r + 1, 12, 0), bits(2, 7, -1, -1, -1));
    check("t6_ch0_wrap", win(0, r + 1, 12, 1), bits(4, 9, -1, -1, -1));
    check("t6_ch1_rs", win(1, r + 1, 12, 0), bits(1, 5, 9, -1, -1));

    wr_cfg(6, 100, 50, 1, 0);
    do_resync(r);
    tick(2);
    cfg_ch = 3'd0; #1;
    check("t6_rd0", 64'(act_rdata), 64'({1'b1, 1'b0, 12'd4, 12'd2}));
    cfg_ch = 3'd1; #1;
    check("t6_rd1", 64'(act_rdata), 64'({1'b1, 1'b0, 12'd3, 12'd1}));
    cfg_ch = 3'd2; #1;
    check("t6_rd2", 64'(act_rdata), 64'({1'b1, 1'b0, 12'd5, 12'd0}));
    cfg_ch = 3'd3; #1;
    check("t6_rd3", 64'(act_rdata), 64'({1'b1, 1'b1, 12'd1, 12'd0}));
    tick(1);

    for (int t = 0; t < 4000; t++) begin
      int dv;
      cfg_we = ($urandom % 4 == 0);
      cfg_ch = 3'($urandom % 8);
      dv = ($urandom % 10 == 0) ? int'($urandom % 200) : int'($urandom % 12);
      cfg_div = W'(dv);
      cfg_phase = W'(($urandom % 2 != 0) ? $urandom % (dv + 1)
                                         : $urandom % (dv + 4));
      cfg_turbo = 1'($urandom % 2);
      cfg_en = ($urandom % 5 != 0);
      resync = ($urandom % 60 == 0);
      if ($urandom % 20 == 0) pause = ~pause;
      reset = ($urandom % 900 == 0);
      tick(1);
    end
    cfg_we = 1'b0;
    resync = 1'b0;
    pause = 1'b0;
    reset = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_strobe_gen.md
Name: clk_strobe_gen

Overview:
- Parametrised, multi-channel clock-enable strobe generator for the Apogee/RK86 platform.
- Replaces the hand-written divider chain in the top level: CPU phase strobes f1/f2, pixel, PIT, DMA and PS/2 ticks.
- Each channel produces a one-cycle enable pulse at a runtime-programmable period and phase.
- Optional turbo mode doubles the pulse rate; configuration changes apply glitch-free at period wrap.

Parameters:
- NUM_CH, 6, number of strobe channels (1..16).
- DIV_W, 12, width of the divisor/phase fields; maximum period 2^DIV_W.
- DEF_DIV, 27, reset terminal count for all channels (period DEF_DIV+1).
- DEF_EN, 1, reset enable state for all channels.

Ports:
- clk  input  1  system clock (clk_sys domain); all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  write strobe for the shadow configuration of channel cfg_ch.
- cfg_ch  input  $clog2(NUM_CH)  channel select, used for both write and readback.
- cfg_div  input  DIV_W  terminal count; period = cfg_div+1.
- cfg_phase  input  DIV_W  count value at which the primary strobe fires.
- cfg_turbo  input  1  enables the second strobe per period.
- cfg_en  input  1  channel enable.
- resync  input  1  global realign of all counters.
- pause  input  1  global freeze.
- stb  output  NUM_CH  one-cycle enable strobes, registered.
- wrap  output  NUM_CH  one-cycle pulse when the channel counter wraps, registered.
- act_rdata  output  2*DIV_W+2  active {en,turbo,div,phase} of channel cfg_ch, combinational readback.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - All counters = 0.
  - Active and shadow configs = {DEF_EN, turbo 0, DEF_DIV, phase 0}.
  - stb = 0, wrap = 0.
- Per channel, normal count (pause=0, resync=0):
  - cnt <= (cnt==div_act) ? 0 : cnt+1.
  - At cnt==div_act, active config <= shadow config, so the new config governs the next period.
- Strobe timing: stb[i] is registered. It is high in the cycle after an edge where:
  - en_act=1 and cnt==phase_act, or
  - en_act=1, turbo_act=1 and cnt==phase2, where phase2 = (phase_act + (div_act+1)/2) mod (div_act+1), integer division.
- Strobe width: exactly 1 clk. Latency from the count match to stb = 1 clk.
- wrap[i] is registered and high in the cycle after the edge where cnt==div_act, independent of en.
- Degenerate periods:
  - div_act=0: period 1, stb high every cycle while enabled. phase2 equals phase_act, so there is a single pulse, not a double.
  - div_act=1 with turbo: phase2 = phase_act^1, so stb is high every cycle.
- Out-of-range phase: phase_act > div_act means the primary strobe never fires. The turbo strobe still fires at the computed phase2. No error flag.
- cfg_we:
  - Writes the shadow config of cfg_ch only; the last write before a wrap wins.
  - A write on the same edge as that channel's wrap lands in the shadow. The wrap loads the pre-write shadow; the new value takes effect at the following wrap.
  - cfg_ch >= NUM_CH: write is ignored.
- resync=1 (takes priority over pause):
  - All cnt <= 0.
  - All active <= shadow, including a shadow being written on the same edge.
  - stb <= 0, wrap <= 0.
  - Used to phase-align f1/f2 after a turbo or divisor change.
- pause=1:
  - Counters and active configs hold.
  - stb = 0, wrap = 0.
  - cfg_we still updates shadows.
  - Used during ioctl download.
- Disabled channel: the counter keeps running so that re-enable stays phase-coherent. Only stb is masked.
- Reset mid-period: counters restart at 0, so the first stb with phase 0 appears in the 2nd cycle after reset is released.

Decomposition:
- Package clk_strobe_pkg holds:
  - typedef struct packed {en, turbo, div[DIV_W], phase[DIV_W]} ch_cfg_t, as a parametrised function-width helper or fixed with the DIV_W_MAX constant.
  - Function half_phase() computing phase2.
  - Reset constants.
- Sub-module clk_strobe_ch, one channel: counter, shadow/active registers, compare, stb/wrap flops.
- The top generates NUM_CH instances plus cfg_ch decode and the readback mux.

Test Plan:
1. Reset, then ch0 default (div 27, phase 0) -> stb[0] pulses every 28 clk; first pulse 2 clk after reset falls; wrap[0] aligned 27 clk later.
2. ch0 {div 27, phase 0, turbo 1}, ch1 {div 27, phase 2, turbo 1}, then resync -> stb[0] at counts 0 and 14, stb[1] at 2 and 16, i.e. the original f1/f2 pattern.
3. Write ch2 div 5 mid-period while div_act = 9 -> the current period completes at 10 clk; subsequent periods are 6 clk; no runt or double pulse.
4. ch3 div 0 -> stb[3] continuously high. Then phase 7 with div 3 -> stb[3] never pulses; wrap[3] still pulses every 4 clk.
5. pause for 50 clk at count 10 of div 27 -> no stb/wrap during the pause; resumes at count 10; the next strobe arrives exactly 18 clk after pause falls.
6. cfg_we to ch1 on the same edge as its wrap, plus resync on the same edge to ch0 -> ch1 new value applies one period late; ch0 applies immediately with count 0; cfg_ch=NUM_CH write leaves all channels unchanged.
